// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one 3-input adder (1-cycle latency) among N_REQ lanes.
// Sums come back tagged with their lane id through a 2-entry in-order result FIFO.
module adder_rr_sched #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int OW    = DW + 2,
    parameter int TW    = $clog2(N_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ*3*DW-1:0] req_data_i,
    output logic [DW-1:0]         add_d1_o,
    output logic [DW-1:0]         add_d2_o,
    output logic [DW-1:0]         add_d3_o,
    input  logic [OW-1:0]         add_sum_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [OW-1:0]         res_data_o,
    output logic [TW-1:0]         res_id_o
);

    logic [TW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           inflight_v_q, inflight_v_d;
    logic [TW-1:0]  inflight_id_q, inflight_id_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [OW-1:0]  head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [TW-1:0]  head_id_q, head_id_d, tail_id_q, tail_id_d;

    logic           pop_s;
    logic           push_s;
    logic [2:0]     occ_s;
    logic           issue_ok_s;
    logic           found_s;
    logic [TW-1:0]  grant_id_s;
    logic [N_REQ-1:0] grant_s;
    logic [TW:0]    idx_s;

    // Occupancy counts the in-flight slot so the FIFO can never overflow;
    // a pop in this cycle frees a slot immediately (res_ready -> req_ready path).
    assign pop_s      = (cnt_q != 2'd0) && res_ready_i;
    assign push_s     = inflight_v_q;
    assign occ_s      = {1'b0, cnt_q} + {2'b00, inflight_v_q} - {2'b00, pop_s};
    assign issue_ok_s = !rst_i && (occ_s < 3'd2);

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found_s    = 1'b0;
        grant_id_s = '0;
        grant_s    = '0;
        idx_s      = '0;
        if (issue_ok_s) begin
            for (int j = 0; j < N_REQ; j++) begin
                idx_s = {1'b0, rr_ptr_q} + (TW+1)'(j);
                idx_s = (idx_s >= (TW+1)'(N_REQ)) ? (idx_s - (TW+1)'(N_REQ)) : idx_s;
                if (!found_s && req_valid_i[idx_s[TW-1:0]]) begin
                    found_s    = 1'b1;
                    grant_id_s = idx_s[TW-1:0];
                end else begin
                    found_s    = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
        grant_s[grant_id_s] = found_s;
    end

    // Operand mux: one-hot grant selects the lane triple, zero when idle.
    always_comb begin
        add_d1_o = '0;
        add_d2_o = '0;
        add_d3_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            add_d1_o = add_d1_o | ({DW{grant_s[i]}} & req_data_i[(i*3+0)*DW +: DW]);
            add_d2_o = add_d2_o | ({DW{grant_s[i]}} & req_data_i[(i*3+1)*DW +: DW]);
            add_d3_o = add_d3_o | ({DW{grant_s[i]}} & req_data_i[(i*3+2)*DW +: DW]);
        end
    end

    // Pointer advance and tag pipe matching the adder's single-cycle latency.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        inflight_v_d  = found_s;
        inflight_id_d = grant_id_s;
        if (found_s) begin
            rr_ptr_d = (grant_id_s == TW'(N_REQ-1)) ? '0 : (grant_id_s + TW'(1));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Head/tail FIFO: head register drives res_* directly and holds when emptied.
    always_comb begin
        cnt_d       = cnt_q;
        head_data_d = head_data_q;
        head_id_d   = head_id_q;
        tail_data_d = tail_data_q;
        tail_id_d   = tail_id_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_data_d = add_sum_i;
                    head_id_d   = inflight_id_q;
                    cnt_d       = 2'd1;
                end else begin
                    tail_data_d = add_sum_i;
                    tail_id_d   = inflight_id_q;
                    cnt_d       = 2'd2;
                end
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_data_d = tail_data_q;
                    head_id_d   = tail_id_q;
                end else begin
                    head_data_d = head_data_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_data_d = tail_data_q;
                    head_id_d   = tail_id_q;
                    tail_data_d = add_sum_i;
                    tail_id_d   = inflight_id_q;
                end else begin
                    head_data_d = add_sum_i;
                    head_id_d   = inflight_id_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q      <= '0;
            inflight_v_q  <= 1'b0;
            inflight_id_q <= '0;
            cnt_q         <= 2'd0;
            head_data_q   <= '0;
            head_id_q     <= '0;
            tail_data_q   <= '0;
            tail_id_q     <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            inflight_v_q  <= inflight_v_d;
            inflight_id_q <= inflight_id_d;
            cnt_q         <= cnt_d;
            head_data_q   <= head_data_d;
            head_id_q     <= head_id_d;
            tail_data_q   <= tail_data_d;
            tail_id_q     <= tail_id_d;
        end
    end

    assign req_ready_o = grant_s;
    assign res_valid_o = (cnt_q != 2'd0);
    assign res_data_o  = head_data_q;
    assign res_id_o    = head_id_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Bench for adder_rr_sched: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_adder_rr_sched;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 10;
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*3*DW-1:0] req_data;
    logic [DW-1:0]     add_d1, add_d2, add_d3;
    logic [OW-1:0]     add_sum;
    logic              res_valid;
    logic              res_ready;
    logic [OW-1:0]     res_data;
    logic [TW-1:0]     res_id;

    int lane_ops [N][3];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_rr_sched #(.N_REQ(N), .DW(DW), .OW(OW), .TW(TW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .add_d1_o(add_d1), .add_d2_o(add_d2), .add_d3_o(add_d3), .add_sum_i(add_sum),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_id_o(res_id)
    );

    // External adder with one register stage.
    always @(posedge clk) add_sum <= OW'(add_d1) + OW'(add_d2) + OW'(add_d3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++)
                req_data[(i*3+k)*DW +: DW] = lane_ops[i][k][DW-1:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    // Reference model: queue of visible results, one pending adder slot, rr pointer.
    typedef struct { int data; int id; } ent_t;
    ent_t mq[$];
    ent_t pend;
    int   pend_v = 0;
    int   rr = 0;
    int   last_d = 0;
    int   last_id = 0;

    always @(negedge clk) begin
        int ev, ed, eid, pop, allowed, g, l, e1, e2, e3;
        logic [N-1:0] er;
        ev  = (mq.size() > 0) ? 1 : 0;
        ed  = ev ? mq[0].data : last_d;
        eid = ev ? mq[0].id : last_id;
        check("res_valid", 32'(res_valid), ev);
        check("res_data", 32'(res_data), ed);
        check("res_id", 32'(res_id), eid);
        pop = (ev != 0 && res_ready) ? 1 : 0;
        allowed = ((mq.size() + pend_v - pop) < 2) ? 1 : 0;
        g = -1;
        if (!rst && allowed != 0)
            for (int j = 0; j < N; j++) begin
                l = (rr + j) % N;
                if (g < 0 && req_valid[l]) g = l;
            end
        er = '0; e1 = 0; e2 = 0; e3 = 0;
        if (g >= 0) begin
            er[g] = 1'b1;
            e1 = lane_ops[g][0]; e2 = lane_ops[g][1]; e3 = lane_ops[g][2];
        end
        check("req_ready", 32'(req_ready), 32'(er));
        check("add_d1", 32'(add_d1), e1);
        check("add_d2", 32'(add_d2), e2);
        check("add_d3", 32'(add_d3), e3);
        if (rst) begin
            mq.delete();
            pend_v = 0; rr = 0; last_d = 0; last_id = 0;
        end else begin
            if (pop != 0) begin
                last_d = mq[0].data; last_id = mq[0].id;
                void'(mq.pop_front());
            end
            if (pend_v != 0) mq.push_back(pend);
            pend_v = (g >= 0) ? 1 : 0;
            if (g >= 0) begin
                pend.data = e1 + e2 + e3;
                pend.id   = g;
                rr = (g + 1) % N;
            end
        end
    end

    initial begin
        logic [N-1:0] hs;
        rst = 1'b1; req_valid = '0; res_ready = 1'b1; req_data = '0;
        for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) lane_ops[i][k] = 0;
        drive_data();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single request on lane 2
        lane_ops[2][0] = 10; lane_ops[2][1] = 20; lane_ops[2][2] = 30;
        drive_data();
        req_valid = 4'b0100;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'h4);
        check("t1_d1", 32'(add_d1), 32'd10);
        check("t1_d2", 32'(add_d2), 32'd20);
        check("t1_d3", 32'(add_d3), 32'd30);
        step(); req_valid = '0;
        @(negedge clk);
        check("t1_rv_c1", 32'(res_valid), 32'd0);
        step();
        @(negedge clk);
        check("t1_rv_c2", 32'(res_valid), 32'd1);
        check("t1_data", 32'(res_data), 32'd60);
        check("t1_id", 32'(res_id), 32'd2);
        step();

        // All lanes, max operands, full throughput
        do_reset();
        for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) lane_ops[i][k] = 255;
        drive_data();
        req_valid = 4'hF; res_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("t2_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                check("t2_data", 32'(res_data), 32'd765);
                check("t2_id", 32'(res_id), 32'((c - 2) % 4));
            end
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Backpressure: two grants then stall, release in order
        do_reset();
        for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) lane_ops[i][k] = i*10 + k + 1;
        drive_data();
        req_valid = 4'hF; res_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t3_grant", 32'(req_ready), (c == 0) ? 32'h1 : (c == 1) ? 32'h2 : 32'h0);
            if (c >= 2) check("t3_hold_id", 32'(res_id), 32'd0);
            step();
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_resume", 32'(req_ready), 32'h4);
        repeat (8) step();
        req_valid = '0;
        repeat (4) step();

        // Fairness between lanes 0 and 3
        do_reset();
        req_valid = 4'b1001; res_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t4_grant", 32'(req_ready), (c % 2 == 1) ? 32'h8 : 32'h1);
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Reset with queued results
        do_reset();
        req_valid = 4'hF; res_ready = 1'b0;
        repeat (4) step();
        rst = 1'b1; req_valid = '0; res_ready = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_rv", 32'(res_valid), 32'd0);
            step();
        end
        req_valid = 4'hF;
        @(negedge clk);
        check("t5_first", 32'(req_ready), 32'h1);
        repeat (4) step();
        req_valid = '0;
        repeat (3) step();

        // Toggling backpressure with fresh data after each handshake
        do_reset();
        for (int i = 0; i < N; i++) for (int k = 0; k < 3; k++) lane_ops[i][k] = int'($urandom_range(0, 255));
        drive_data();
        req_valid = 4'hF;
        for (int c = 0; c < 200; c++) begin
            res_ready = (c % 2 == 0);
            @(negedge clk);
            hs = req_ready & req_valid;
            step();
            for (int i = 0; i < N; i++)
                if (hs[i]) for (int k = 0; k < 3; k++) lane_ops[i][k] = int'($urandom_range(0, 255));
            drive_data();
        end
        req_valid = '0; res_ready = 1'b1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
